// File: rtl/button_debounce_pkg.sv
// Shared types and default timing constants for the button debounce block.
package button_debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int LONG_CYCLES_DEF     = 5000000;

endpackage

// File: rtl/button_debounce_if.sv
// Button bundle between the pad side and the Wishbone button/LED peripheral.
interface button_debounce_if #(
    parameter int NUM_BUTTONS = 3
);
    logic [NUM_BUTTONS-1:0] buttons_raw;
    logic [NUM_BUTTONS-1:0] buttons_stable;
    logic [NUM_BUTTONS-1:0] press_pulse;
    logic [NUM_BUTTONS-1:0] release_pulse;
    logic [NUM_BUTTONS-1:0] long_press;

    modport master (
        output buttons_raw,
        input  buttons_stable, press_pulse, release_pulse, long_press
    );

    modport slave (
        input  buttons_raw,
        output buttons_stable, press_pulse, release_pulse, long_press
    );
endinterface

// File: rtl/button_debounce_channel.sv
// One button channel: 2-FF synchroniser followed by a counter-qualified FSM.
// Long-press detection is built only when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
module button_debounce_channel
    import button_debounce_pkg::*;
#(
    parameter int CNT_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CNT_WIDTH  = 24,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_WIDTH) - 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range for CNT_WIDTH");
    end
    if (LONG_CYCLES < 1 || LONG_CYCLES > (2 ** LONG_CNT_WIDTH) - 1) begin : g_bad_long
        $error("LONG_CYCLES out of range for LONG_CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync_q1;
    logic                 sync;
    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;

    // NOTE: non-blocking assignments make the two flops a real shift chain;
    // blocking ones would collapse it into a single stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync    <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync    <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_LOW;
            cnt           <= '0;
            stable        <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle so each assertion lasts one clock.
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                S_LOW: begin
                    if (sync) begin
                        state <= S_RISE;
                        cnt   <= '0;
                    end
                end
                S_RISE: begin
                    if (!sync) begin
                        state <= S_LOW;
                    end else if (cnt == CNT_LAST) begin
                        state       <= S_HIGH;
                        stable      <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                S_HIGH: begin
                    if (!sync) begin
                        state <= S_FALL;
                        cnt   <= '0;
                    end
                end
                S_FALL: begin
                    if (sync) begin
                        state <= S_HIGH;
                    end else if (cnt == CNT_LAST) begin
                        state         <= S_LOW;
                        stable        <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                default: state <= S_LOW;
            endcase
        end
    end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam logic [LONG_CNT_WIDTH-1:0] HOLD_LAST = LONG_CNT_WIDTH'(LONG_CYCLES - 1);

    logic [LONG_CNT_WIDTH-1:0] hold_cnt;

    // Cleared only when a press is accepted: a bounce back from S_FALL is the
    // same press, and parking at HOLD_LAST+1 keeps the event to one per press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (state == S_RISE && sync && cnt == CNT_LAST) begin
                hold_cnt <= '0;
            end else if (state == S_HIGH || state == S_FALL) begin
                if (hold_cnt < HOLD_LAST) begin
                    hold_cnt <= hold_cnt + LONG_CNT_WIDTH'(1);
                end else if (hold_cnt == HOLD_LAST) begin
                    hold_cnt   <= hold_cnt + LONG_CNT_WIDTH'(1);
                    long_press <= 1'b1;
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Debounces NUM_BUTTONS pad inputs for the Wishbone button/LED peripheral.
// Define BUTTON_DEBOUNCE_LONG_PRESS_EN to enable per-channel long-press events.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int NUM_BUTTONS     = 3,
    parameter int CNT_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CNT_WIDTH  = 24,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    button_debounce_if.slave   btn
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        button_debounce_channel #(
            .CNT_WIDTH       (CNT_WIDTH),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CNT_WIDTH  (LONG_CNT_WIDTH),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clk           (clk),
            .reset_n       (reset_n),
            .raw           (btn.buttons_raw[i]),
            .stable        (btn.buttons_stable[i]),
            .press_pulse   (btn.press_pulse[i]),
            .release_pulse (btn.release_pulse[i]),
            .long_press    (btn.long_press[i])
        );
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Conditions raw pad button inputs before they reach the Wishbone button/LED peripheral's `buttons` input.
- Per channel: a 2-FF synchroniser, then a counter-based debounce FSM.
- Outputs per channel: a glitch-free stable level, plus one-cycle press and release event pulses for the peripheral's register/interrupt logic.
- Sits between `io_in[9:7]` and the Wishbone button/LED peripheral inside `user_project_wrapper`.

Parameters:
- NUM_BUTTONS, 3, number of independent button channels.
- CNT_WIDTH, 16, width of the per-channel debounce counter.
- DEBOUNCE_CYCLES, 50000, consecutive clocks the synchronised input must hold a new level before it is accepted. Legal range is 1 to 2^CNT_WIDTH-1.
- LONG_CNT_WIDTH, 24, width of the long-press counter. Used only with the optional feature.
- LONG_CYCLES, 5000000, clocks held in the pressed state before a long-press event. Legal range is 1 to 2^LONG_CNT_WIDTH-1.

Ports:
- clk  input  1  system clock (`wb_clk_i`).
- reset_n  input  1  reset, asynchronous assert, active-low.
- buttons_raw  input  NUM_BUTTONS  asynchronous pad inputs, active-high.
- buttons_stable  output  NUM_BUTTONS  debounced level per channel.
- press_pulse  output  NUM_BUTTONS  one-cycle pulse on an accepted 0->1 transition.
- release_pulse  output  NUM_BUTTONS  one-cycle pulse on an accepted 1->0 transition.
- long_press  output  NUM_BUTTONS  one-cycle pulse when the long-press threshold is reached. Constant 0 when the feature is compiled out.

Behaviour:
- Interface (decided): one clock `clk`. Reset `reset_n` is asynchronous and active-low.
- Reset: all outputs 0; sync flops 0; every FSM in S_LOW; all counters 0. Reset asserted mid-operation aborts any pending transition immediately and emits no pulses.
- Synchroniser: `sync_q1 <= raw`, `sync <= sync_q1`. All further logic uses `sync` only.
- FSM per channel, states S_LOW, S_RISE, S_HIGH, S_FALL:
  - S_LOW: if `sync`=1 go to S_RISE, cnt <= 0.
  - S_RISE: if `sync`=0 go to S_LOW (glitch rejected, no pulse). Else if cnt == DEBOUNCE_CYCLES-1 go to S_HIGH, `buttons_stable` <= 1, `press_pulse` <= 1. Else cnt++.
  - S_HIGH: if `sync`=0 go to S_FALL, cnt <= 0.
  - S_FALL: mirror of S_RISE. On `sync`=1 return to S_HIGH. On reaching the count go to S_LOW, `buttons_stable` <= 0, `release_pulse` <= 1.
- Latency: with raw steady from the first sampling edge E1, `buttons_stable` changes and the pulse asserts on edge E(DEBOUNCE_CYCLES+3).
- Pulses are registered and high for exactly one clock. At most one of press/release is asserted per channel per cycle.
- `buttons_stable` equals 1 exactly in S_HIGH and S_FALL.
- Bounce: any input toggle during S_RISE or S_FALL restarts the qualification from the current stable state. A bounce train shorter than DEBOUNCE_CYCLES produces no output change.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1, so no wrap can occur.
- Channels are fully independent. Simultaneous events on several channels all pulse in the same cycle.

Optional Feature:
- Macro: `BUTTON_DEBOUNCE_LONG_PRESS_EN`.
- Defined:
  - A per-channel hold counter clears on entry to S_HIGH and increments each cycle in S_HIGH/S_FALL while below LONG_CYCLES-1.
  - On reaching LONG_CYCLES-1 it emits one `long_press` pulse, at most once per press, then saturates.
  - The counter is cleared in S_LOW.
  - An accepted release before the threshold produces no `long_press`.
- Undefined: no counter logic; `long_press` is tied to 0.

Decomposition:
- Package `button_debounce_pkg` holds:
  - the 2-bit state enum (S_LOW=0, S_RISE=1, S_HIGH=2, S_FALL=3);
  - default constants DEBOUNCE_CYCLES_DEF and LONG_CYCLES_DEF.
- Sub-module `button_debounce_channel` (one synchroniser, FSM and counters) is instantiated NUM_BUTTONS times in a generate loop by `button_debounce`.

Test Plan:
- Bench setup: DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
- Clean press: raw[0] 0->1 held -> `buttons_stable[0]`=1 and `press_pulse[0]`=1 for one cycle on edge 7. Other channels stay 0.
- Glitch: raw[1] high for 3 clocks then low -> no pulse; `buttons_stable[1]` stays 0.
- Bounce then settle: raw[2] toggles 1,0,1,0,1 at 1-clock spacing, then held high -> exactly one `press_pulse`, 7 edges after the final rise. Subsequent clean release -> one `release_pulse` 7 edges after the fall.
- Simultaneous: all raw rise together -> press_pulse=3'b111 in a single cycle.
- Reset mid-qualification: assert reset_n=0 while in S_RISE (cnt=2) -> outputs 0 asynchronously. After release with raw still high, press occurs 7 edges after the first post-reset sampling edge.
- Long press (macro defined): hold raw[0] high -> `long_press[0]` pulses once, 10 clocks after entering S_HIGH, and not again while held. Release after 5 clocks in S_HIGH -> no `long_press`. Macro undefined -> `long_press` constant 0.
